// File: rtl/bicoh_pkg.sv
// Shared definitions for the bicoherence triad scheduler: FSM encoding,
// Q14 constants and the index-width helper.
package bicoh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_ACCUM,
    ST_STORE
  } sched_state_e;

  localparam int Q14_ONE  = 16384;
  localparam int Q14_HALF = Q14_ONE / 2;

  // Index width that stays at least one bit wide for a single triad.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/triad_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after start
// (inclusive) or strictly after start, wrapping through index 0.
module triad_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [IDXW-1:0] start,
  input  logic            inclusive,
  output logic [IDXW-1:0] idx,
  output logic            wrapped,
  output logic            none
);

  int j;

  always_comb begin
    idx  = start;
    none = (mask == '0);
    j    = 0;
    // Walk from the farthest candidate back so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + (inclusive ? 0 : 1) + k;
      if (j >= N) j = j - N;
      if (mask[j[IDXW-1:0]]) idx = j[IDXW-1:0];
    end
    wrapped = inclusive ? (idx < start) : (idx <= start);
  end

endmodule

// File: rtl/bicoherence_triad_scheduler.sv
// Time-multiplexes one bicoherence monitor over NUM_TRIADS oscillator triads:
// clear, settle, dwell, capture, and keep a per-triad result table.
module bicoherence_triad_scheduler
  import bicoh_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int NUM_TRIADS = 4,
  parameter int SETTLE     = 8,
  parameter int DWELL      = 64,
  parameter int THRESH     = Q14_HALF >> (14 - FRAC),
  localparam int IDXW      = idx_w(NUM_TRIADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic [NUM_TRIADS-1:0]   triad_mask,
  input  logic signed [WIDTH-1:0] bicoh_in,
  input  logic [IDXW-1:0]         rd_idx,
  output logic [IDXW-1:0]         triad_sel,
  output logic                    mon_clear,
  output logic                    busy,
  output logic                    result_valid,
  output logic [IDXW-1:0]         result_idx,
  output logic signed [WIDTH-1:0] result_value,
  output logic                    sweep_done,
  output logic [NUM_TRIADS-1:0]   high_mask,
  output logic signed [WIDTH-1:0] rd_value
);

  localparam int CMAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic signed [WIDTH-1:0] THR_S = WIDTH'(THRESH);

  function automatic logic signed [WIDTH-1:0] clamp_pos(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? '0 : x;
  endfunction

  function automatic logic above_thresh(input logic signed [WIDTH-1:0] x);
    return x > THR_S;
  endfunction

  sched_state_e state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] tab_q [NUM_TRIADS];
  logic signed [WIDTH-1:0] tab_d [NUM_TRIADS];
  logic [NUM_TRIADS-1:0] high_q, high_d;
  logic mon_clear_q, mon_clear_d;
  logic rv_q, rv_d, sd_q, sd_d;
  logic [IDXW-1:0] res_idx_q, res_idx_d;
  logic signed [WIDTH-1:0] res_val_q, res_val_d;
  logic signed [WIDTH-1:0] stored;

  logic [IDXW-1:0] pick_idx;
  logic pick_wrapped, pick_none;

  // IDLE resumes at ptr itself; every other decision moves strictly past it.
  triad_rr_pick #(.N(NUM_TRIADS), .IDXW(IDXW)) u_pick (
    .mask      (triad_mask),
    .start     (ptr_q),
    .inclusive (state_q == ST_IDLE),
    .idx       (pick_idx),
    .wrapped   (pick_wrapped),
    .none      (pick_none)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tab_d     = tab_q;
    high_d    = high_q;
    res_idx_d = res_idx_q;
    res_val_d = res_val_q;
    rv_d      = 1'b0;
    sd_d      = 1'b0;
    stored    = clamp_pos(bicoh_in);
    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable && !pick_none) begin
            ptr_d   = pick_idx;
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR, ST_SETTLE, ST_ACCUM: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (!triad_mask[ptr_q]) begin
            if (pick_none) begin
              state_d = ST_IDLE;
            end else begin
              ptr_d   = pick_idx;
              state_d = ST_CLEAR;
            end
          end else if (state_q == ST_CLEAR) begin
            state_d = ST_SETTLE;
            cnt_d   = CNTW'(SETTLE - 1);
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
          end else if (state_q == ST_SETTLE) begin
            state_d = ST_ACCUM;
            cnt_d   = CNTW'(DWELL - 1);
          end else begin
            state_d = ST_STORE;
          end
        end
        ST_STORE: begin
          tab_d[ptr_q]  = stored;
          high_d[ptr_q] = above_thresh(stored);
          res_idx_d     = ptr_q;
          res_val_d     = stored;
          rv_d          = 1'b1;
          if (!pick_none) begin
            ptr_d = pick_idx;
            sd_d  = pick_wrapped;
          end
          state_d = (enable && !pick_none) ? ST_CLEAR : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    mon_clear_d = clk_en ? (state_d == ST_CLEAR) : mon_clear_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      tab_q       <= '{default: '0};
      high_q      <= '0;
      mon_clear_q <= 1'b0;
      rv_q        <= 1'b0;
      sd_q        <= 1'b0;
      res_idx_q   <= '0;
      res_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tab_q       <= tab_d;
      high_q      <= high_d;
      mon_clear_q <= mon_clear_d;
      rv_q        <= rv_d;
      sd_q        <= sd_d;
      res_idx_q   <= res_idx_d;
      res_val_q   <= res_val_d;
    end
  end

  assign triad_sel    = ptr_q;
  assign mon_clear    = mon_clear_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = rv_q;
  assign sweep_done   = sd_q;
  assign result_idx   = res_idx_q;
  assign result_value = res_val_q;
  assign high_mask    = high_q & triad_mask;
  assign rd_value     = (int'(rd_idx) < NUM_TRIADS) ? tab_q[rd_idx] : '0;

endmodule
